// File: rtl/sr_flag_sequencer.sv
// sr_flag_sequencer: arbitrates two requesters and pulses one SR flag in a bank, then verifies Q readback.
module sr_flag_sequencer #(
    parameter int N_FLAGS   = 8,
    parameter int IDX_W     = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [IDX_W-1:0]   a_idx,
    input  logic               a_op,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [IDX_W-1:0]   b_idx,
    input  logic               b_op,
    output logic [N_FLAGS-1:0] s_out,
    output logic [N_FLAGS-1:0] r_out,
    output logic               ff_en,
    input  logic [N_FLAGS-1:0] q_in,
    output logic               done,
    output logic               err,
    output logic               done_src
);
    typedef enum logic [1:0] {IDLE, PULSE, CHECK} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [IDX_W-1:0] idx, sel_idx;
    logic op, src, rr;
    logic grant_a, grant_b, accept, in_rng, qbit;
    logic [N_FLAGS-1:0] onehot;
    always_comb begin
        grant_a  = a_valid & (~b_valid | ~rr);
        grant_b  = b_valid & (~a_valid | rr);
        accept   = ~rst & (state == IDLE) & (grant_a | grant_b);
        sel_idx  = grant_b ? b_idx : a_idx;
        in_rng   = 32'(idx) < N_FLAGS;
        onehot   = N_FLAGS'(1) << idx;
        qbit     = |(q_in & onehot);
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (32'(sel_idx) < N_FLAGS) ? PULSE : CHECK;
            PULSE:   if (cnt == 4'(PULSE_CYC - 1)) state_nx = CHECK;
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // every output is gated by rst so the bank never sees S and R together, even mid-reset
        a_ready  = ~rst & (state == IDLE) & grant_a;
        b_ready  = ~rst & (state == IDLE) & grant_b;
        ff_en    = ~rst & (state == PULSE);
        s_out    = (ff_en & op) ? onehot : '0;
        r_out    = (ff_en & ~op) ? onehot : '0;
        done     = ~rst & (state == CHECK);
        err      = done & (~in_rng | (qbit != op));
        done_src = done & src;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            op    <= 1'b0;
            src   <= 1'b0;
            rr    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state == PULSE) ? cnt + 4'd1 : '0;
            if (accept) begin
                idx <= sel_idx;
                op  <= grant_b ? b_op : a_op;
                src <= grant_b;
                rr  <= grant_a;
            end
        end
    end
endmodule

// File: tb/tb_sr_flag_sequencer.sv
// tb_sr_flag_sequencer: directed checks of arbitration, pulse timing, readback error and reset abort.
module tb_sr_flag_sequencer;
    logic clk = 0, rst = 1;
    logic a_valid = 0, a_op = 0, b_valid = 0, b_op = 0;
    logic [3:0] a_idx = 0, b_idx = 0;
    logic a_ready, b_ready, ff_en, done, err, done_src;
    logic [7:0] s_out, r_out, q_in, bank = 0, force_mask = 0;
    int checks = 0, failures = 0;

    sr_flag_sequencer #(.N_FLAGS(8), .IDX_W(4), .PULSE_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_op(a_op),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_op(b_op),
        .s_out(s_out), .r_out(r_out), .ff_en(ff_en), .q_in(q_in),
        .done(done), .err(err), .done_src(done_src)
    );

    always #5 clk = ~clk;
    // bank model: S sets, R clears, only while enabled
    always @(posedge clk) if (ff_en) bank <= (bank | s_out) & ~r_out;
    assign q_in = bank & ~force_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) chk("sr_exclusive", 32'(s_out & r_out), 0);

    initial begin
        a_valid = 1;
        tick(); tick();
        #1;
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_outputs", {8'(s_out), 8'(r_out), 13'd0, ff_en, done, err}, 0);
        a_valid = 0; rst = 0;
        // single set idx=3
        tick();
        a_valid = 1; a_idx = 3; a_op = 1; #1;
        chk("t1_a_ready", 32'(a_ready), 1);
        tick(); a_valid = 0; #1;
        chk("t1_p1_s", 32'(s_out), 32'h08);
        chk("t1_p1_en", {ff_en, a_ready}, 2'b10);
        tick();
        chk("t1_p2_s", 32'(s_out), 32'h08);
        chk("t1_p2_en", 32'(ff_en), 1);
        tick();
        chk("t1_done", {done, err, done_src, ff_en}, 4'b1000);
        chk("t1_chk_s", 32'(s_out), 0);
        tick();
        chk("t1_done_gone", 32'(done), 0);
        // same idx, opposite ops, A first after reset
        rst = 1; tick(); rst = 0;
        a_valid = 1; a_idx = 5; a_op = 1;
        b_valid = 1; b_idx = 5; b_op = 0; #1;
        chk("t2_grant_a", {a_ready, b_ready}, 2'b10);
        tick(); a_valid = 0; #1;
        chk("t2_a_s", 32'(s_out), 32'h20);
        tick(); tick();
        chk("t2_a_done", {done, err, done_src}, 3'b100);
        chk("t2_b_wait", 32'(b_ready), 0);
        tick();
        chk("t2_grant_b", {a_ready, b_ready}, 2'b01);
        tick(); b_valid = 0; #1;
        chk("t2_b_r", 32'(r_out), 32'h20);
        tick(); tick();
        chk("t2_b_done", {done, err, done_src}, 3'b101);
        chk("t2_q5", 32'(q_in[5]), 0);
        tick();
        // round robin with both held valid
        rst = 1; tick(); rst = 0;
        a_valid = 1; a_idx = 1; a_op = 1;
        b_valid = 1; b_idx = 2; b_op = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t3_grant%0d", i), {a_ready, b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick(); tick(); tick();
            chk($sformatf("t3_src%0d", i), {done, done_src}, {1'b1, 1'(i % 2)});
            tick();
        end
        a_valid = 0; b_valid = 0;
        // out of range index
        tick();
        a_valid = 1; a_idx = 9; a_op = 1; #1;
        chk("t4_a_ready", 32'(a_ready), 1);
        tick(); a_valid = 0; #1;
        chk("t4_done", {done, err, ff_en}, 3'b110);
        chk("t4_no_drive", {8'(s_out), 8'(r_out)}, 0);
        tick();
        chk("t4_done_gone", {done, err}, 2'b00);
        // readback mismatch on idx 2
        force_mask = 8'h04;
        a_valid = 1; a_idx = 2; a_op = 1;
        tick(); a_valid = 0;
        tick(); tick();
        chk("t5_err", {done, err}, 2'b11);
        tick(); force_mask = 0;
        // reset during second pulse cycle
        a_valid = 1; a_idx = 4; a_op = 1;
        tick(); a_valid = 0;
        tick();
        chk("t6_pulse2", 32'(ff_en), 1);
        rst = 1; a_valid = 1; a_idx = 6; b_valid = 1; b_idx = 7;
        tick();
        chk("t6_rst_out", {8'(s_out), 8'(r_out), ff_en, done, err, done_src, a_ready, b_ready}, 0);
        rst = 0; #1;
        chk("t6_rr_a", {a_ready, b_ready}, 2'b10);
        tick(); a_valid = 0; b_valid = 0; #1;
        chk("t6_no_done", {done, s_out[6]}, 2'b01);
        tick(); tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sr_flag_sequencer.md
SR_FLAG_SEQUENCER -- requirements
Module: sr_flag_sequencer

Interface
REQ-001 The module SHALL have parameter N_FLAGS, default 8: number of SR flip-flops in the controlled bank.
REQ-002 The module SHALL have parameter IDX_W, default 3: flag index width; N_FLAGS SHALL be at most 2**IDX_W.
REQ-003 The module SHALL have parameter PULSE_CYC, default 2, legal range 1..15: number of cycles a set/reset pulse is held.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Ports a_valid (input, 1), a_ready (output, 1), a_idx (input, IDX_W), a_op (input, 1, 1=set 0=clear): requester A command channel.
REQ-007 Ports b_valid, b_ready, b_idx, b_op: requester B command channel, same widths and meanings as A.
REQ-008 Port s_out, output, N_FLAGS: per-flag S drive to the bank.
REQ-009 Port r_out, output, N_FLAGS: per-flag R drive to the bank.
REQ-010 Port ff_en, output, 1: enable driven to the bank clock/enable inputs; high only while pulsing.
REQ-011 Port q_in, input, N_FLAGS: Q readback from the bank.
REQ-012 Ports done (output, 1), err (output, 1), done_src (output, 1, 0=A 1=B): completion pulse, mismatch flag, and originating requester.

Function
REQ-013 FSM states SHALL be IDLE, PULSE and CHECK.
REQ-014 In IDLE, a_ready SHALL equal grant_a, and b_ready SHALL equal grant_b; both SHALL be 0 in PULSE and CHECK.
REQ-015 Grant rule: only one valid requester -> that requester is granted; both valid -> the requester named by the priority pointer rr (0=A, 1=B) is granted; neither valid -> no grant.
REQ-016 The grant SHALL be a combinational function of valid and rr; at most one of a_ready and b_ready SHALL be 1 in any cycle.
REQ-017 A command SHALL be accepted when valid&ready; on acceptance, idx, op and source SHALL be latched, the FSM SHALL move to PULSE, and rr SHALL be set to the non-granted requester.
REQ-018 A command with idx >= N_FLAGS SHALL be accepted, SHALL produce no s_out/r_out/ff_en activity, and SHALL go directly to CHECK with err=1.
REQ-019 In PULSE, ff_en SHALL be 1, and exactly bit idx of s_out (op=1) or of r_out (op=0) SHALL be 1; all other bits SHALL be 0.
REQ-020 PULSE SHALL last exactly PULSE_CYC cycles, counted by an internal counter, then the FSM SHALL move to CHECK.
REQ-021 s_out[i] and r_out[i] SHALL never both be 1 for any i in any cycle, including during reset.
REQ-022 In CHECK, outputs SHALL be s_out=0, r_out=0 and ff_en=0.
REQ-023 In CHECK, done SHALL be 1 for exactly one cycle, with done_src set to the latched source and err = (q_in[idx] != op) or idx out of range; the FSM SHALL then return to IDLE.
REQ-024 err and done_src SHALL be valid only while done=1, and SHALL be 0 otherwise.
REQ-025 Latency: acceptance at cycle t -> PULSE during t+1..t+PULSE_CYC -> done at t+PULSE_CYC+1 -> next acceptance no earlier than t+PULSE_CYC+2.
REQ-026 Valid deasserted while not ready SHALL be ignored; requesters hold a command until accepted.
REQ-027 Two requests to the same idx with opposite op SHALL be serviced sequentially in grant order; the final flag value SHALL equal the last op serviced.

Reset
REQ-028 While rst=1, the FSM SHALL enter IDLE and rr SHALL be 0 (A first).
REQ-029 While rst=1, the pulse counter and latched command SHALL be cleared, and s_out, r_out, ff_en, done, err, done_src, a_ready and b_ready SHALL all be 0.
REQ-030 rst asserted mid-PULSE SHALL drop s_out/r_out/ff_en to 0 on the next edge and suppress done; the aborted command SHALL not be retried.

Verification
REQ-031 After reset, A valid, idx=3, op=1, q_in follows s_out: a_ready=1 at t; s_out=8'h08 and ff_en=1 for t+1..t+2; done=1, err=0, done_src=0 at t+3.
REQ-032 A and B valid in the same cycle, both with idx=5, A op=1, B op=0: A is serviced first, then B; two done pulses with done_src 0 then 1; final q_in[5]=0; s_out[5] and r_out[5] are never both 1.
REQ-033 Both requesters held valid for 4 commands: grants alternate A,B,A,B.
REQ-034 A idx=9 with N_FLAGS=8: no pulse; done=1 and err=1 one cycle after acceptance.
REQ-035 Set idx=2 with q_in[2] forced to 0: done=1, err=1.
REQ-036 rst asserted in the second PULSE cycle: all outputs are 0 on the next edge; no done; rr=0; A is granted next.
